// File: rtl/intr_ctrl.sv
// Interrupt cause/mask/moderation controller; reads return 1 cycle after reg_rd, intr_request is registered.
// No backpressure: every register strobe and source pulse is accepted the cycle it is presented.
module intr_ctrl #(
  parameter int NUM_SRC  = 16,
  parameter int ITR_UNIT = 256
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic [NUM_SRC-1:0] intr_src,
  input  logic [2:0]         reg_addr,
  input  logic               reg_wr,
  input  logic [31:0]        reg_wdata,
  input  logic               reg_rd,
  output logic [31:0]        reg_rdata,
  output logic               reg_rvalid,
  output logic               intr_request
);

  localparam int PW = $clog2(ITR_UNIT);

  localparam logic [2:0] A_ICR = 3'd0;
  localparam logic [2:0] A_ICS = 3'd1;
  localparam logic [2:0] A_IMS = 3'd2;
  localparam logic [2:0] A_IMC = 3'd3;
  localparam logic [2:0] A_ITR = 3'd4;

  logic [NUM_SRC-1:0] pending, pending_nxt, mask, mask_nxt, set_v, clr_v;
  logic [15:0]        itr, thr_cnt;
  logic [PW-1:0]      presc;
  logic [31:0]        rd_mux;
  logic               active, irq_nxt, irq_fall;
  logic               wr_icr, wr_ics, wr_ims, wr_imc, wr_itr, rd_icr;
  logic               unused_wdata;

  assign unused_wdata = ^reg_wdata;

  assign wr_icr = reg_wr && (reg_addr == A_ICR);
  assign wr_ics = reg_wr && (reg_addr == A_ICS);
  assign wr_ims = reg_wr && (reg_addr == A_IMS);
  assign wr_imc = reg_wr && (reg_addr == A_IMC);
  assign wr_itr = reg_wr && (reg_addr == A_ITR);
  assign rd_icr = reg_rd && (reg_addr == A_ICR);

  // New causes always beat a same-cycle clear, so a read-to-clear never loses an event.
  always_comb begin
    set_v = intr_src;
    if (wr_ics) set_v = set_v | reg_wdata[NUM_SRC-1:0];
    clr_v = '0;
    if (wr_icr) clr_v = reg_wdata[NUM_SRC-1:0];
    if (rd_icr) clr_v = '1;
    pending_nxt = set_v | (pending & ~clr_v);

    mask_nxt = mask;
    if (wr_ims)      mask_nxt = mask | reg_wdata[NUM_SRC-1:0];
    else if (wr_imc) mask_nxt = mask & ~reg_wdata[NUM_SRC-1:0];
  end

  always_comb begin
    rd_mux = '0;
    case (reg_addr)
      A_ICR:   rd_mux[NUM_SRC-1:0] = pending;
      A_IMS:   rd_mux[NUM_SRC-1:0] = mask;
      A_ITR:   rd_mux[15:0]        = itr;
      default: rd_mux = '0;
    endcase
  end

  assign active   = |(pending & mask);
  assign irq_nxt  = intr_request ? active : (active && (thr_cnt == 16'd0));
  assign irq_fall = intr_request && !irq_nxt;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pending      <= '0;
      mask         <= '0;
      itr          <= '0;
      reg_rdata    <= '0;
      reg_rvalid   <= 1'b0;
      intr_request <= 1'b0;
    end else begin
      pending      <= pending_nxt;
      mask         <= mask_nxt;
      if (wr_itr) itr <= reg_wdata[15:0];
      reg_rdata    <= reg_rd ? rd_mux : 32'd0;
      reg_rvalid   <= reg_rd;
      intr_request <= irq_nxt;
    end
  end

  // The hold-off window restarts on every deassertion, using the itr value live at that moment.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      thr_cnt <= '0;
      presc   <= '0;
    end else if (irq_fall) begin
      thr_cnt <= itr;
      presc   <= '0;
    end else if (thr_cnt != 16'd0) begin
      if (presc == PW'(ITR_UNIT - 1)) begin
        presc   <= '0;
        thr_cnt <= thr_cnt - 16'd1;
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// Randomised and directed bench for intr_ctrl against a cycle-level behavioural model.
module tb_intr_ctrl;
  localparam int NS   = 16;
  localparam int UNIT = 256;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [NS-1:0] intr_src = '0;
  logic [2:0]    reg_addr = '0;
  logic          reg_wr = 1'b0;
  logic [31:0]   reg_wdata = '0;
  logic          reg_rd = 1'b0;
  logic [31:0]   reg_rdata;
  logic          reg_rvalid;
  logic          intr_request;

  int checks = 0;
  int errors = 0;

  // Model: pending/mask/itr as plain values; throttle as an absolute "earliest rise" edge index.
  logic [NS-1:0] m_pend, m_mask;
  logic [15:0]   m_itr;
  logic          m_irq, m_rv;
  logic [31:0]   m_rd;
  longint        cyc, ready_edge;

  intr_ctrl #(.NUM_SRC(NS), .ITR_UNIT(UNIT)) dut (
    .aclk(aclk), .aresetn(aresetn), .intr_src(intr_src), .reg_addr(reg_addr),
    .reg_wr(reg_wr), .reg_wdata(reg_wdata), .reg_rd(reg_rd), .reg_rdata(reg_rdata),
    .reg_rvalid(reg_rvalid), .intr_request(intr_request)
  );

  always #5 aclk = ~aclk;

  task automatic model_reset();
    m_pend = '0; m_mask = '0; m_itr = '0; m_irq = 1'b0; m_rv = 1'b0; m_rd = '0;
    ready_edge = 0;
  endtask

  task automatic step(input logic [NS-1:0] src, input logic [2:0] a, input logic w,
                      input logic r, input logic [31:0] d);
    logic          act;
    logic [NS-1:0] setb, clrb;
    intr_src = src; reg_addr = a; reg_wr = w; reg_rd = r; reg_wdata = d;
    @(posedge aclk);
    act  = |(m_pend & m_mask);
    m_rv = r;
    m_rd = '0;
    if (r) begin
      if (a == 3'd0) m_rd = 32'(m_pend);
      else if (a == 3'd2) m_rd = 32'(m_mask);
      else if (a == 3'd4) m_rd = 32'(m_itr);
    end
    if (m_irq) begin
      if (!act) begin
        m_irq = 1'b0;
        ready_edge = cyc + 1 + longint'(m_itr) * UNIT;
      end
    end else if (act && cyc >= ready_edge) begin
      m_irq = 1'b1;
    end
    setb = src | ((w && a == 3'd1) ? d[NS-1:0] : '0);
    clrb = ((w && a == 3'd0) ? d[NS-1:0] : '0) | ((r && a == 3'd0) ? {NS{1'b1}} : '0);
    m_pend = setb | (m_pend & ~clrb);
    if (w && a == 3'd2) m_mask = m_mask | d[NS-1:0];
    if (w && a == 3'd3) m_mask = m_mask & ~d[NS-1:0];
    if (w && a == 3'd4) m_itr = d[15:0];
    cyc++;
    #1;
    intr_src = '0; reg_wr = 1'b0; reg_rd = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 3'd0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic test_reset();
    model_reset();
    cyc = 0;
    #12;
    checks++; if (intr_request !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", intr_request); end
    checks++; if (reg_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b want 0", reg_rvalid); end
    checks++; if (reg_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h want 0", reg_rdata); end
    @(negedge aclk); aresetn = 1'b1;
    @(posedge aclk); #1;
  endtask

  task automatic test_basic();
    step('0, 3'd2, 1'b1, 1'b0, 32'h1);
    step(16'h1, 3'd0, 1'b0, 1'b0, 32'd0);
    checks++; if (intr_request !== 1'b0) begin errors++; $display("FAIL basic_pre got %b want 0", intr_request); end
    idle(1);
    checks++; if (intr_request !== 1'b1) begin errors++; $display("FAIL basic_rise got %b want 1", intr_request); end
    step('0, 3'd0, 1'b0, 1'b1, 32'd0);
    checks++; if (reg_rvalid !== 1'b1 || reg_rdata !== 32'h1) begin
      errors++; $display("FAIL basic_icr got %b/%h want 1/00000001", reg_rvalid, reg_rdata); end
    idle(1);
    checks++; if (intr_request !== 1'b0) begin errors++; $display("FAIL basic_fall got %b want 0", intr_request); end
  endtask

  task automatic test_masked();
    step('0, 3'd3, 1'b1, 1'b0, 32'hFFFF);
    step(16'h8, 3'd0, 1'b0, 1'b0, 32'd0);
    idle(2);
    checks++; if (intr_request !== 1'b0) begin errors++; $display("FAIL masked_hold got %b want 0", intr_request); end
    step('0, 3'd0, 1'b0, 1'b1, 32'd0);
    checks++; if (reg_rdata !== 32'h8) begin errors++; $display("FAIL masked_icr got %h want 00000008", reg_rdata); end
    step(16'h8, 3'd0, 1'b0, 1'b0, 32'd0);
    step('0, 3'd2, 1'b1, 1'b0, 32'h8);
    checks++; if (intr_request !== 1'b0) begin errors++; $display("FAIL masked_early got %b want 0", intr_request); end
    idle(1);
    checks++; if (intr_request !== 1'b1) begin errors++; $display("FAIL masked_unmask got %b want 1", intr_request); end
    step('0, 3'd0, 1'b0, 1'b1, 32'd0);
    idle(1);
    checks++; if (intr_request !== 1'b0) begin errors++; $display("FAIL masked_clear got %b want 0", intr_request); end
  endtask

  task automatic test_throttle();
    int low, bad;
    step('0, 3'd2, 1'b1, 1'b0, 32'h1);
    step('0, 3'd4, 1'b1, 1'b0, 32'd2);
    step(16'h1, 3'd0, 1'b0, 1'b0, 32'd0);
    idle(1);
    checks++; if (intr_request !== 1'b1) begin errors++; $display("FAIL thr_first got %b want 1", intr_request); end
    step('0, 3'd0, 1'b0, 1'b1, 32'd0);
    low = 0; bad = 0;
    for (int i = 0; i < 1000; i++) begin
      step((i % 5 == 0) ? 16'h1 : 16'h0, 3'd0, 1'b0, 1'b0, 32'd0);
      if (intr_request !== m_irq) bad++;
      if (intr_request === 1'b1) break;
      low++;
    end
    checks++; if (low !== 2 * UNIT + 1) begin errors++; $display("FAIL thr_gap got %0d want %0d", low, 2 * UNIT + 1); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL thr_model got %0d diffs want 0", bad); end
    step('0, 3'd4, 1'b1, 1'b0, 32'd0);
    step('0, 3'd0, 1'b0, 1'b1, 32'd0);
    checks++; if (reg_rdata !== 32'h1) begin errors++; $display("FAIL thr_coalesce got %h want 00000001", reg_rdata); end
    idle(1);
  endtask

  task automatic test_back_to_back();
    step('0, 3'd2, 1'b1, 1'b0, 32'h3);
    step(16'h1, 3'd0, 1'b0, 1'b0, 32'd0);
    idle(1);
    step(16'h2, 3'd0, 1'b0, 1'b1, 32'd0);
    checks++; if (reg_rdata !== 32'h1) begin errors++; $display("FAIL b2b_old got %h want 00000001", reg_rdata); end
    idle(1);
    checks++; if (intr_request !== 1'b1) begin errors++; $display("FAIL b2b_irq got %b want 1", intr_request); end
    step('0, 3'd0, 1'b0, 1'b1, 32'd0);
    checks++; if (reg_rdata !== 32'h2) begin errors++; $display("FAIL b2b_kept got %h want 00000002", reg_rdata); end
    idle(1);
    step(16'h2, 3'd0, 1'b0, 1'b0, 32'd0);
    idle(1);
    checks++; if (intr_request !== 1'b1) begin errors++; $display("FAIL b2b_reassert got %b want 1", intr_request); end
    step('0, 3'd0, 1'b0, 1'b1, 32'd0);
    idle(1);
  endtask

  task automatic test_ics_imc();
    step('0, 3'd3, 1'b1, 1'b0, 32'hFFFF);
    step('0, 3'd2, 1'b1, 1'b0, 32'h4);
    step('0, 3'd1, 1'b1, 1'b0, 32'h5);
    idle(1);
    checks++; if (intr_request !== 1'b1) begin errors++; $display("FAIL ics_rise got %b want 1", intr_request); end
    step('0, 3'd3, 1'b1, 1'b0, 32'h4);
    idle(1);
    checks++; if (intr_request !== 1'b0) begin errors++; $display("FAIL imc_fall got %b want 0", intr_request); end
    step('0, 3'd0, 1'b0, 1'b1, 32'd0);
    checks++; if (reg_rdata !== 32'h5) begin errors++; $display("FAIL ics_icr got %h want 00000005", reg_rdata); end
    step('0, 3'd5, 1'b0, 1'b1, 32'd0);
    checks++; if (reg_rvalid !== 1'b1 || reg_rdata !== 32'h0) begin
      errors++; $display("FAIL unmapped_rd got %b/%h want 1/00000000", reg_rvalid, reg_rdata); end
  endtask

  task automatic test_random();
    logic [2:0]  a;
    logic        w, r;
    logic [31:0] d;
    logic [NS-1:0] s;
    for (int i = 0; i < 600; i++) begin
      a = 3'($urandom_range(0, 7));
      w = ($urandom_range(0, 99) < 30);
      r = ($urandom_range(0, 99) < 30);
      d = $urandom;
      if (a == 3'd4) d = (d & 32'hFFFF_0000) | 32'($urandom_range(0, 1));
      s = ($urandom_range(0, 3) == 0) ? (NS'($urandom) & NS'($urandom)) : '0;
      step(s, a, w, r, d);
      checks++; if (intr_request !== m_irq) begin errors++; $display("FAIL rnd_irq cyc %0d got %b want %b", cyc, intr_request, m_irq); end
      checks++; if (reg_rvalid !== m_rv) begin errors++; $display("FAIL rnd_rvalid cyc %0d got %b want %b", cyc, reg_rvalid, m_rv); end
      if (m_rv) begin
        checks++; if (reg_rdata !== m_rd) begin errors++; $display("FAIL rnd_rdata cyc %0d got %h want %h", cyc, reg_rdata, m_rd); end
      end
    end
  endtask

  task automatic test_async_reset();
    step('0, 3'd4, 1'b1, 1'b0, 32'd1);
    step('0, 3'd2, 1'b1, 1'b0, 32'h1);
    step(16'h1, 3'd0, 1'b0, 1'b0, 32'd0);
    idle(1);
    step('0, 3'd0, 1'b0, 1'b1, 32'd0);
    idle(1);
    step(16'h3, 3'd0, 1'b0, 1'b0, 32'd0);
    step('0, 3'd2, 1'b0, 1'b1, 32'd0);
    checks++; if (reg_rvalid !== 1'b1 || reg_rdata === 32'd0) begin
      errors++; $display("FAIL arst_pre got %b/%h want 1/nonzero", reg_rvalid, reg_rdata); end
    #2; aresetn = 1'b0; #1;
    model_reset();
    checks++; if (reg_rvalid !== 1'b0 || reg_rdata !== 32'd0 || intr_request !== 1'b0) begin
      errors++; $display("FAIL arst_async got %b/%h/%b want 0/0/0", reg_rvalid, reg_rdata, intr_request); end
    @(negedge aclk); aresetn = 1'b1;
    @(posedge aclk); #1;
    step('0, 3'd0, 1'b0, 1'b1, 32'd0);
    checks++; if (reg_rdata !== 32'd0) begin errors++; $display("FAIL arst_icr got %h want 0", reg_rdata); end
    step('0, 3'd2, 1'b0, 1'b1, 32'd0);
    checks++; if (reg_rdata !== 32'd0) begin errors++; $display("FAIL arst_ims got %h want 0", reg_rdata); end
    step('0, 3'd4, 1'b0, 1'b1, 32'd0);
    checks++; if (reg_rdata !== 32'd0) begin errors++; $display("FAIL arst_itr got %h want 0", reg_rdata); end
    step('0, 3'd2, 1'b1, 1'b0, 32'h1);
    step(16'h1, 3'd0, 1'b0, 1'b0, 32'd0);
    idle(1);
    checks++; if (intr_request !== 1'b1) begin errors++; $display("FAIL arst_unthrottled got %b want 1", intr_request); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_masked();
    test_throttle();
    test_back_to_back();
    test_ics_imc();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
